// File: rtl/pipe_pkg.sv
// Shared constants and types for the inter-stage pipeline buffers.
package pipe_pkg;

  // Default bundle widths of the D/X stage
  localparam int unsigned CTRL_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 108;

  // Bit positions inside the D/X control bundle
  localparam int unsigned CB_ALUSRC   = 0;
  localparam int unsigned CB_MEMTOREG = 1;
  localparam int unsigned CB_REGWRITE = 2;
  localparam int unsigned CB_MEMREAD  = 3;
  localparam int unsigned CB_MEMWRITE = 4;
  localparam int unsigned CB_BRANCH   = 5;
  localparam int unsigned CB_JUMP     = 6;
  localparam int unsigned CB_ALUOP0   = 7;
  localparam int unsigned CB_ALUOP1   = 8;
  localparam int unsigned CB_ALUOP2   = 9;
  localparam int unsigned CB_HALT     = 10;

  // Field widths and offsets used when packing the data bundle
  localparam int unsigned FIELD16_W = 16;
  localparam int unsigned REGID_W   = 4;
  localparam int unsigned DF_PC     = 0;
  localparam int unsigned DF_RS1V   = 16;
  localparam int unsigned DF_RS2V   = 32;
  localparam int unsigned DF_IMM    = 48;
  localparam int unsigned DF_ALU    = 64;
  localparam int unsigned DF_MEMD   = 80;
  localparam int unsigned DF_RD     = 96;
  localparam int unsigned DF_RS1    = 100;
  localparam int unsigned DF_RS2    = 104;

  // Number of entries held by the buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One buffer slot: valid bit plus control and data registers.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Reset wipes everything; clear only drops valid so the payload holds
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Handshaked inter-stage buffer with optional 2-entry skid and stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_state_e        r_state;
  occ_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_accept;
  logic              w_pop;
  logic              w_h_load, w_h_clr, w_s_load, w_s_clr;
  logic              w_h_valid, w_s_valid;
  logic [CTRL_W-1:0] w_h_ctrl, w_s_ctrl, w_h_ctrl_in;
  logic [DATA_W-1:0] w_h_data, w_s_data, w_h_data_in;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = w_h_valid & out_ready;

  // The head only ever loads from the skid slot when that slot is occupied (FULL pop)
  assign w_h_ctrl_in = w_s_valid ? w_s_ctrl : in_ctrl;
  assign w_h_data_in = w_s_valid ? w_s_data : in_data;

  // Next occupancy and per-slot load/clear; flush overrides both handshakes
  always_comb begin
    w_state_nxt = r_state;
    w_h_load    = 1'b0;
    w_h_clr     = 1'b0;
    w_s_load    = 1'b0;
    w_s_clr     = 1'b0;
    if (flush) begin
      w_h_clr     = 1'b1;
      w_s_clr     = 1'b1;
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_h_load    = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_h_load = 1'b1;
          end else if (w_accept) begin
            w_s_load    = 1'b1;
            w_state_nxt = FULL;
          end else if (w_pop) begin
            w_h_clr     = 1'b1;
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_h_load    = 1'b1;
            w_s_clr     = 1'b1;
            w_state_nxt = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  pipe_entry #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_head (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_h_load),
    .i_clr  (w_h_clr),
    .i_ctrl (w_h_ctrl_in),
    .i_data (w_h_data_in),
    .o_valid(w_h_valid),
    .o_ctrl (w_h_ctrl),
    .o_data (w_h_data)
  );

  if (SKID) begin : g_skid
    logic r_in_ready;

    pipe_entry #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_skid (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (w_s_load),
      .i_clr  (w_s_clr),
      .i_ctrl (in_ctrl),
      .i_data (in_data),
      .o_valid(w_s_valid),
      .o_ctrl (w_s_ctrl),
      .o_data (w_s_data)
    );

    // Registered ready; reset loads 1 and the output gate with rst keeps it low
    // during reset, so it reads 1 in the first cycle after release
    always_ff @(posedge clk) begin
      if (rst) r_in_ready <= 1'b1;
      else     r_in_ready <= (w_state_nxt != FULL);
    end

    assign in_ready = r_in_ready & ~rst;
  end else begin : g_bare
    logic w_unused_skid;

    assign w_s_valid     = 1'b0;
    assign w_s_ctrl      = '0;
    assign w_s_data      = '0;
    assign w_unused_skid = w_s_load | w_s_clr;
    assign in_ready      = ~rst & (~w_h_valid | out_ready);
  end

  // Saturating count of cycles where the downstream holds off a valid head
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_h_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = w_h_valid;
  assign out_ctrl  = w_h_valid ? w_h_ctrl : '0;
  assign out_data  = w_h_data;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=1 (CNT_W=4) and one SKID=0 instance.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic         s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [10:0]  s_in_ctrl, s_out_ctrl;
  logic [107:0] s_in_data, s_out_data;
  logic [1:0]   s_occ;
  logic [3:0]   s_stall_cnt;

  // SKID=0 instance signals
  logic         n_rst, n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [10:0]  n_in_ctrl, n_out_ctrl;
  logic [107:0] n_in_data, n_out_data;
  logic [1:0]   n_occ;
  logic [15:0]  n_stall_cnt;

  pipe_stage_buf #(.CTRL_W(11), .DATA_W(108), .SKID(1'b1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(s_rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ctrl(s_in_ctrl), .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .occupancy(s_occ), .stall_cnt(s_stall_cnt)
  );

  pipe_stage_buf #(.CTRL_W(11), .DATA_W(108), .SKID(1'b0), .CNT_W(16)) u_bare (
    .clk(clk), .rst(n_rst), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_ctrl(n_in_ctrl), .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_ctrl(n_out_ctrl), .out_data(n_out_data), .occupancy(n_occ), .stall_cnt(n_stall_cnt)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: FIFO of entries plus last shown head data and stall count
  typedef struct {
    logic [10:0]  c;
    logic [107:0] d;
  } ent_t;
  ent_t         q[$];
  logic [107:0] m_last;
  int unsigned  m_cnt;
  int unsigned  m_cmax;
  bit           m_known;
  int           sel;

  // Outputs observed in the most recent step (pre-edge)
  logic         g_ov, g_ir;
  logic [10:0]  g_c;
  logic [107:0] g_d;
  logic [1:0]   g_occ;
  logic [31:0]  g_cnt;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d t=%0t): got %0h want %0h", nm, sel, $time, act, exp);
    end
  endfunction

  function automatic logic [107:0] rand108();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[107:0];
  endfunction

  task automatic select(input int which);
    sel     = which;
    q.delete();
    m_known = 1'b0;
    m_cnt   = 0;
    m_last  = '0;
    m_cmax  = (which == 0) ? 15 : 65535;
  endtask

  // Apply one cycle of inputs, check pre-edge outputs, advance the model past the edge
  task automatic step(input logic iv, input logic [10:0] ic, input logic [107:0] id,
                      input logic orr, input logic fl, input logic rs);
    int unsigned sz;
    logic        m_ir;
    if (sel == 0) begin
      s_in_valid = iv; s_in_ctrl = ic; s_in_data = id; s_out_ready = orr; s_flush = fl; s_rst = rs;
    end else begin
      n_in_valid = iv; n_in_ctrl = ic; n_in_data = id; n_out_ready = orr; n_flush = fl; n_rst = rs;
    end
    #1;
    if (sel == 0) begin
      g_ov = s_out_valid; g_ir = s_in_ready; g_c = s_out_ctrl; g_d = s_out_data;
      g_occ = s_occ; g_cnt = 32'(s_stall_cnt);
    end else begin
      g_ov = n_out_valid; g_ir = n_in_ready; g_c = n_out_ctrl; g_d = n_out_data;
      g_occ = n_occ; g_cnt = 32'(n_stall_cnt);
    end
    sz   = q.size();
    m_ir = !rs && ((sel == 0) ? (sz < 2) : (sz == 0 || orr));
    chk("in_ready", 128'(g_ir), 128'(m_ir));
    if (m_known) begin
      chk("out_valid", 128'(g_ov), 128'(sz > 0));
      chk("out_ctrl", 128'(g_c), (sz > 0) ? 128'(q[0].c) : 128'(0));
      chk("out_data", 128'(g_d), 128'(m_last));
      chk("occupancy", 128'(g_occ), 128'(sz));
      chk("stall_cnt", 128'(g_cnt), 128'(m_cnt));
    end
    if (rs) begin
      q.delete();
      m_cnt   = 0;
      m_last  = '0;
      m_known = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (sz > 0 && !orr && m_cnt < m_cmax) m_cnt++;
      if (sz > 0 && orr) void'(q.pop_front());
      if (iv && m_ir) q.push_back('{c: ic, d: id});
      if (q.size() > 0) m_last = q[0].d;
    end
    @(negedge clk);
  endtask

  task automatic random_run(input int cycles);
    logic         cur_iv;
    logic [10:0]  cur_c;
    logic [107:0] cur_d;
    logic         orr, fl, rs;
    cur_iv = 1'b0; cur_c = '0; cur_d = '0;
    g_ir = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      // Upstream keeps its payload stable until it has been taken
      if (!cur_iv || g_ir) begin
        cur_iv = ($urandom_range(0, 3) != 0);
        cur_c  = 11'($urandom);
        cur_d  = rand108();
      end
      orr = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      rs  = ($urandom_range(0, 149) == 0);
      step(cur_iv, cur_c, cur_d, orr, fl, rs);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [10:0] ic;
    logic [15:0] id;
    logic        orr, fl, rs;
    logic        e_ov;
    logic [10:0] e_c;
    logic [15:0] e_d;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [10:0] ic, logic [15:0] id, logic orr, logic fl,
                              logic rs, logic e_ov, logic [10:0] e_c, logic [15:0] e_d,
                              logic [1:0] e_occ, logic e_ir, logic [3:0] e_cnt);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.orr = orr; v.fl = fl; v.rs = rs;
    v.e_ov = e_ov; v.e_c = e_c; v.e_d = e_d; v.e_occ = e_occ; v.e_ir = e_ir; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = '0; s_in_data = '0; s_out_ready = 1'b0;
    n_rst = 1'b1; n_flush = 1'b0; n_in_valid = 1'b0; n_in_ctrl = '0; n_in_data = '0; n_out_ready = 1'b0;

    //        iv ictrl   idata   or fl rs | ov ctrl    data    occ ir cnt
    // stream 1..5 with out_ready high
    tbl.push_back(mk(1, 11'h1,   16'h1,   1, 0, 0,  0, 11'h0,   16'h0,   0, 1, 0));
    tbl.push_back(mk(1, 11'h2,   16'h2,   1, 0, 0,  1, 11'h1,   16'h1,   1, 1, 0));
    tbl.push_back(mk(1, 11'h3,   16'h3,   1, 0, 0,  1, 11'h2,   16'h2,   1, 1, 0));
    tbl.push_back(mk(1, 11'h4,   16'h4,   1, 0, 0,  1, 11'h3,   16'h3,   1, 1, 0));
    tbl.push_back(mk(1, 11'h5,   16'h5,   1, 0, 0,  1, 11'h4,   16'h4,   1, 1, 0));
    tbl.push_back(mk(0, 11'h0,   16'h0,   1, 0, 0,  1, 11'h5,   16'h5,   1, 1, 0));
    tbl.push_back(mk(0, 11'h0,   16'h0,   0, 0, 0,  0, 11'h0,   16'h5,   0, 1, 0));
    // backpressure A, B, C
    tbl.push_back(mk(1, 11'hA,   16'hA,   0, 0, 0,  0, 11'h0,   16'h5,   0, 1, 0));
    tbl.push_back(mk(1, 11'hB,   16'hB,   0, 0, 0,  1, 11'hA,   16'hA,   1, 1, 0));
    tbl.push_back(mk(1, 11'hC,   16'hC,   0, 0, 0,  1, 11'hA,   16'hA,   2, 0, 1));
    tbl.push_back(mk(1, 11'hC,   16'hC,   0, 0, 0,  1, 11'hA,   16'hA,   2, 0, 2));
    tbl.push_back(mk(1, 11'hC,   16'hC,   1, 0, 0,  1, 11'hA,   16'hA,   2, 0, 3));
    tbl.push_back(mk(1, 11'hC,   16'hC,   1, 0, 0,  1, 11'hB,   16'hB,   1, 1, 3));
    tbl.push_back(mk(0, 11'h0,   16'h0,   1, 0, 0,  1, 11'hC,   16'hC,   1, 1, 3));
    tbl.push_back(mk(0, 11'h0,   16'h0,   0, 0, 0,  0, 11'h0,   16'hC,   0, 1, 3));
    // fill, then flush while FULL and while empty with a same-cycle input
    tbl.push_back(mk(1, 11'h11,  16'h11,  0, 0, 0,  0, 11'h0,   16'hC,   0, 1, 3));
    tbl.push_back(mk(1, 11'h12,  16'h12,  0, 0, 0,  1, 11'h11,  16'h11,  1, 1, 3));
    tbl.push_back(mk(1, 11'h7FF, 16'h7FF, 0, 1, 0,  1, 11'h11,  16'h11,  2, 0, 4));
    tbl.push_back(mk(1, 11'h7FF, 16'h7FF, 1, 1, 0,  0, 11'h0,   16'h11,  0, 1, 4));
    tbl.push_back(mk(0, 11'h0,   16'h0,   1, 0, 0,  0, 11'h0,   16'h11,  0, 1, 4));
    // reset mid-stream with FULL buffer
    tbl.push_back(mk(1, 11'h21,  16'h21,  0, 0, 0,  0, 11'h0,   16'h11,  0, 1, 4));
    tbl.push_back(mk(1, 11'h22,  16'h22,  0, 0, 0,  1, 11'h21,  16'h21,  1, 1, 4));
    tbl.push_back(mk(0, 11'h0,   16'h0,   0, 0, 1,  1, 11'h21,  16'h21,  2, 0, 5));
    tbl.push_back(mk(0, 11'h0,   16'h0,   1, 0, 0,  0, 11'h0,   16'h0,   0, 1, 0));
    tbl.push_back(mk(0, 11'h0,   16'h0,   1, 0, 0,  0, 11'h0,   16'h0,   0, 1, 0));

    // ---------------- SKID=1 instance ----------------
    @(negedge clk);
    select(0);
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 1);
    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].ic, 108'(tbl[i].id), tbl[i].orr, tbl[i].fl, tbl[i].rs);
      chk($sformatf("tbl%0d.out_valid", i), 128'(g_ov), 128'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.out_ctrl", i), 128'(g_c), 128'(tbl[i].e_c));
      chk($sformatf("tbl%0d.out_data", i), 128'(g_d), 128'(tbl[i].e_d));
      chk($sformatf("tbl%0d.occupancy", i), 128'(g_occ), 128'(tbl[i].e_occ));
      chk($sformatf("tbl%0d.in_ready", i), 128'(g_ir), 128'(tbl[i].e_ir));
      chk($sformatf("tbl%0d.stall_cnt", i), 128'(g_cnt), 128'(tbl[i].e_cnt));
    end

    // stall counter saturation at 15 with CNT_W=4
    step(1, 11'h33, 108'h33, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, '0, 0, 0, 0);
    chk("sat.stall_cnt", 128'(g_cnt), 128'(15));
    step(0, '0, '0, 0, 0, 0);
    chk("sat.hold", 128'(g_cnt), 128'(15));
    step(0, '0, '0, 1, 0, 0);

    random_run(600);

    // ---------------- SKID=0 instance ----------------
    s_rst = 1'b1; s_in_valid = 1'b0; s_flush = 1'b0;
    select(1);
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 1);
    step(1, 11'h0AA, 108'h100, 0, 0, 0);
    step(1, 11'h0BB, 108'h200, 0, 0, 0);
    chk("bare.ready_low", 128'(g_ir), 128'(0));
    chk("bare.head", 128'(g_d), 128'(108'h100));
    step(1, 11'h0BB, 108'h200, 1, 0, 0);
    chk("bare.ready_comb", 128'(g_ir), 128'(1));
    step(0, '0, '0, 0, 0, 0);
    chk("bare.replaced_data", 128'(g_d), 128'(108'h200));
    chk("bare.replaced_ctrl", 128'(g_c), 128'(11'h0BB));
    chk("bare.occ", 128'(g_occ), 128'(1));
    chk("bare.cnt", 128'(g_cnt), 128'(1));

    random_run(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised, handshaked successor to the fixed-width inter-stage flop banks (D/X, X/M, M/W) of the pipelined CPU.
- Carries one control vector and one data vector per instruction, with a valid bit, ready/valid backpressure and a synchronous flush that inserts a bubble.
- Selectable 2-entry skid mode breaks the combinational ready path between stages.
- Counts cycles in which the downstream stage stalls.

Parameters:
- CTRL_W, 11: width of the control bundle (ALUsrc, MemtoReg, RegWrite, ...).
- DATA_W, 108: width of the data bundle (six 16-bit fields plus three 4-bit register IDs).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and any same-cycle input.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_ctrl  out  CTRL_W  head control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  head data bundle; holds its last value when out_valid=0.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst=1 at an edge):
  - Both entries are invalidated.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=0 while rst is high. It reads 1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all held entries, with no output.
- Handshakes:
  - Accept occurs when in_valid & in_ready.
  - Pop occurs when out_valid & out_ready.
  - Entries leave in FIFO order.
  - Latency is one cycle: an entry accepted at edge N appears at out_* after edge N, unless older entries are still held.
- SKID=1, states EMPTY (0), ONE (1), FULL (2):
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL. Pop without accept -> EMPTY. Accept with pop -> ONE, and the new entry becomes head.
  - FULL: pop -> ONE, and the skid entry moves to head. Accept is impossible in FULL.
  - in_ready is registered and equals (next state != FULL). There is no combinational path from out_ready to in_ready.
- SKID=0:
  - Single entry; occupancy is 0 or 1.
  - in_ready = ~rst & (~out_valid | out_ready), combinational.
  - Simultaneous accept and pop replaces the head.
- Flush:
  - Has priority over accept and pop.
  - At the edge: all entries are invalidated and the same-cycle input is dropped. Next cycle out_valid=0, out_ctrl=0, occupancy=0.
  - in_ready is 1 the cycle after a flush, unless rst is high.
- Bubble: out_ctrl is forced to zero whenever out_valid=0, so RegWrite, MemWrite and halt never fire downstream from an invalid slot.
- stall_cnt:
  - Increments at each edge where out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- in_valid asserted while in_ready=0: the entry is not taken. Upstream must hold in_ctrl and in_data stable until accept.

Decomposition:
- Package pipe_pkg holds:
  - Named bit indices for the D/X control bundle.
  - Default CTRL_W and DATA_W constants.
  - The occupancy-state enum (EMPTY, ONE, FULL).
  - Field offset constants for packing the 16-bit and 4-bit data fields into the data bundle.
- Sub-module pipe_entry: valid bit plus ctrl and data registers, with load, clear and synchronous reset. It is instantiated once for the head and, when SKID=1, once for the skid slot.

Test Plan:
- Reset then stream: rst for 2 cycles, then in_valid=1 with data 0x1..0x5 and out_ready=1 -> out_data is 0x1..0x5 on consecutive cycles, each one cycle after accept; occupancy stays at 1; stall_cnt=0.
- Backpressure (SKID=1): hold out_ready=0, push 0xA, 0xB, 0xC -> 0xA and 0xB accepted; in_ready=0 from the cycle after 0xB; 0xC is held off. Release out_ready -> order 0xA, 0xB, 0xC; stall_cnt equals the number of stalled cycles.
- Flush with FULL buffer plus a same-cycle in_valid carrying in_ctrl=0x7FF -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x7FF never appears at the output.
- SKID=0: out_ready=0 with head valid -> in_ready=0 in the same cycle. Assert out_ready and in_valid together -> head replaced at the next edge.
- Saturation with CNT_W=4: 20 stalled cycles -> stall_cnt=15 and holds at 15.
- Reset mid-stream with FULL buffer -> all outputs return to their reset values; no stale entry emerges after rst deasserts.
